// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: default payload widths
// and the occupancy state encoding.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W_DEF = 32;
    localparam int unsigned PIPE_CTRL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the elastic stage: valid bit, control field, data field.
// clear_i has priority over load_i and drops valid/ctrl while keeping data,
// so control bits are zero whenever the entry holds no beat.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
    parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Entry register: clear beats load; data survives a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake and flush.
// Optional feature macro: PIPE_SKID_EN adds a second (skid) entry and makes
// in_ready a registered signal; without it the stage is a single slot with a
// combinational in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
    parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    pipe_state_e       state_q, state_d;
    logic              in_xfer, out_xfer;
    logic              main_load, main_clr;
    logic [DATA_W-1:0] main_din;
    logic [CTRL_W-1:0] main_cin;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_load, skid_clr, skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_ready_q;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    // Registered ready: low only while both entries are occupied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b1;
        else      in_ready_q <= (state_d != ST_FULL);
    end

    // A flushed cycle swallows the offered beat, so it is acknowledged.
    assign in_ready = in_ready_q | flush;
`else
    assign in_ready = out_ready | ~out_valid | flush;
`endif

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_din),
        .ctrl_i  (main_cin),
        .valid_o (out_valid),
        .data_o  (out_data),
        .ctrl_o  (out_ctrl)
    );

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_EMPTY;
        else      state_q <= state_d;
    end

    // Next-state and slot steering; flush overrides every transfer.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_din  = in_data;
        main_cin  = in_ctrl;
`ifdef PIPE_SKID_EN
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (skid_valid) begin
            main_din = skid_data;
            main_cin = skid_ctrl;
        end
`endif
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
`ifdef PIPE_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
`ifdef PIPE_SKID_EN
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
`else
                        main_load = 1'b1;
`endif
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_FULL: begin
                    if (out_xfer) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (works with or without
// PIPE_SKID_EN defined).
module tb_pipe_stage_elastic;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PIPE_SKID_EN
    localparam int HELD = 2;
`else
    localparam int HELD = 1;
`endif

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_pat(input int mode, input int c);
        case (mode)
            0:       return (c % 2) == 0;
            1:       return !(c >= 3 && c <= 6);
            default: return 1'b1;
        endcase
    endfunction

    // Streams n beats base, base+1, ... with ctrl = index+1, under an
    // out_ready pattern; checks order, ctrl, hold stability and completion.
    task automatic run_stream(input logic [31:0] base, input int n, input int mode);
        int          sent = 0;
        int          recv = 0;
        logic        ov, ordy, ir;
        logic [31:0] od;
        logic [7:0]  oc;
        for (int c = 0; c < 60 && recv < n; c++) begin
            out_ready = ready_pat(mode, c);
            in_valid  = (sent < n);
            in_data   = base + 32'(sent);
            in_ctrl   = 8'(sent + 1);
            #1;
            ov = out_valid; ordy = out_ready; ir = in_ready; od = out_data; oc = out_ctrl;
            if (!ov) check("bubble_ctrl", 64'(oc), 64'd0);
`ifndef PIPE_SKID_EN
            check("ready_mirror", 64'(ir), ov ? 64'(ordy) : 64'd1);
`endif
            if (mode == 2) begin
                check("run_ready", 64'(ir), 64'd1);
                check("run_valid", 64'(ov), 64'(c != 0));
            end
            @(posedge clk);
            #1;
            if (ov && ordy) begin
                check("order_data", 64'(od), 64'(base + 32'(recv)));
                check("order_ctrl", 64'(oc), 64'(recv + 1));
                recv++;
            end else if (ov) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(od));
                check("hold_ctrl", 64'(out_ctrl), 64'(oc));
            end
            if (in_valid && ir) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("all_delivered", 64'(recv), 64'(n));
        step();
    endtask

    // Loads n beats with out_ready held low so they stay in the stage.
    task automatic load_beats(input int n, input logic [31:0] base, input logic [7:0] ctrl);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            in_ctrl  = ctrl;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Free-flowing stream, then toggling and stalled downstream.
        run_stream(32'h10, 4, 2);
        run_stream(32'h01, 8, 0);
        run_stream(32'hA0, 6, 1);

        // Flush with held beats: ctrl squashed, data kept, offered beat lost.
        load_beats(HELD, 32'h70, 8'hFF);
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        check("fl_pre_ctrl", 64'(out_ctrl), 64'hFF);
`ifdef PIPE_SKID_EN
        check("full_ready", 64'(in_ready), 64'd0);
`endif
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h11;
        #1;
        check("fl_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_data_kept", 64'(out_data), 64'h70);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_no_ghost", 64'(out_valid), 64'd0);

        // Flush together with out_ready: head beat still leaves.
        load_beats(HELD, 32'h55, 8'h5A);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flo_valid", 64'(out_valid), 64'd1);
        check("flo_data", 64'(out_data), 64'h55);
        step();
        flush = 1'b0;
        check("flo_after", 64'(out_valid), 64'd0);
        step();
        check("flo_skid_gone", 64'(out_valid), 64'd0);

        // Asynchronous reset while holding beats.
        load_beats(HELD, 32'h30, 8'h0C);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_ctrl", 64'(out_ctrl), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 32'h44; in_ctrl = 8'h03; out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", 64'(out_data), 64'h44);
        check("post_rst_ctrl", 64'(out_ctrl), 64'h03);
        step();
        check("post_rst_drain", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
